// File: rtl/fetch_if.sv
// Fetch/decode boundary: decode drives stall/redirect, fetch returns pc and IF/ID.
interface fetch_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic                  if_id_valid;

  modport master (
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  pc,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid
  );

  modport slave (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output pc,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, instruction memory, byte loader, IF/ID reg.
module fetch_stage #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_if.slave                fif,
  input  logic                  load_en,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  input  logic                  start,
  input  logic                  halt,
  output logic                  loading,
  output logic                  running,
  output logic [ADDR_WIDTH-1:0] load_words,
  output logic                  load_ovf
);
  localparam int IDX_W = $clog2(IMEM_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [IMEM_DEPTH];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] words_q, words_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [23:0]           buf_q, buf_d;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [IDX_W-1:0]      fetch_idx;
  logic [1:0]            unused_rp_lo;

  assign unused_rp_lo = fif.redirect_pc[1:0];
  assign fetch_idx    = pc_q[IDX_W+1:2];
  assign mem_wdata    = {load_byte, buf_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    valid_d    = valid_q;
    words_d    = words_q;
    ovf_d      = ovf_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    buf_d      = buf_q;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d    = S_LOAD;
          word_idx_d = '0;
          byte_cnt_d = '0;
          words_d    = '0;
          ovf_d      = 1'b0;
        end else if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!load_en) begin
          // a partially assembled word is dropped
          state_d    = S_IDLE;
          byte_cnt_d = '0;
        end else if (load_byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: buf_d[7:0]   = load_byte;
            2'd1: buf_d[15:8]  = load_byte;
            2'd2: buf_d[23:16] = load_byte;
            default: begin
              mem_we     = 1'b1;
              word_idx_d = word_idx_q + IDX_W'(1);
              words_d    = words_q + ADDR_WIDTH'(1);
              if (word_idx_q == IDX_W'(IMEM_DEPTH - 1))
                ovf_d = 1'b1;
            end
          endcase
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (fif.redirect_valid) begin
          pc_d    = {fif.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
          valid_d = 1'b0;
        end else if (!fif.stall) begin
          instr_d = mem_q[fetch_idx];
          id_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(4);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      id_pc_q    <= '0;
      valid_q    <= 1'b0;
      words_q    <= '0;
      ovf_q      <= 1'b0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      valid_q    <= valid_d;
      words_q    <= words_d;
      ovf_q      <= ovf_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem_q[word_idx_q] <= mem_wdata;
  end

  assign fif.pc          = pc_q;
  assign fif.if_id_instr = instr_q;
  assign fif.if_id_pc    = id_pc_q;
  assign fif.if_id_valid = valid_q;
  assign loading         = (state_q == S_LOAD);
  assign running         = (state_q == S_RUN);
  assign load_words      = words_q;
  assign load_ovf        = ovf_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default build plus a 4-word memory build.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        le  [2];
  logic        lbv [2];
  logic [7:0]  lb  [2];
  logic        st  [2];
  logic        hl  [2];
  logic        ld  [2];
  logic        rn  [2];
  logic [15:0] lw  [2];
  logic        ov  [2];

  fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) fa ();
  fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) fb ();

  fetch_stage #(.IMEM_DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .fif(fa.slave),
    .load_en(le[0]), .load_byte_valid(lbv[0]), .load_byte(lb[0]),
    .start(st[0]), .halt(hl[0]),
    .loading(ld[0]), .running(rn[0]),
    .load_words(lw[0]), .load_ovf(ov[0])
  );

  fetch_stage #(.IMEM_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .fif(fb.slave),
    .load_en(le[1]), .load_byte_valid(lbv[1]), .load_byte(lb[1]),
    .start(st[1]), .halt(hl[1]),
    .loading(ld[1]), .running(rn[1]),
    .load_words(lw[1]), .load_ovf(ov[1])
  );

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } fetch_t;

  fetch_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [15:0] p);
    fetch_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  task automatic check_fetch(input int sel, input string tag);
    fetch_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s observed=fetch expected=empty_scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, sel ? fb.if_id_instr : fa.if_id_instr, e.instr);
      chk({tag, "_pc"}, {16'h0, sel ? fb.if_id_pc : fa.if_id_pc},
          {16'h0, e.pc});
      chk({tag, "_valid"}, {31'h0, sel ? fb.if_id_valid : fa.if_id_valid},
          32'h1);
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    lbv[sel] = 1'b1;
    lb[sel]  = b;
    step();
    lbv[sel] = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8]);
  endtask

  task automatic enter_load(input int sel);
    le[sel] = 1'b1;
    step();
  endtask

  task automatic leave_load(input int sel);
    le[sel] = 1'b0;
    step();
  endtask

  task automatic pulse_start(input int sel);
    st[sel] = 1'b1;
    step();
    st[sel] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      le[s] = 0; lbv[s] = 0; lb[s] = 0; st[s] = 0; hl[s] = 0;
    end
    fa.stall = 0; fa.redirect_valid = 0; fa.redirect_pc = 0;
    fb.stall = 0; fb.redirect_valid = 0; fb.redirect_pc = 0;

    step();
    step();
    chk("rst_pc", {16'h0, fa.pc}, 32'h0);
    chk("rst_valid", {31'h0, fa.if_id_valid}, 32'h0);
    chk("rst_instr", fa.if_id_instr, 32'h0);
    chk("rst_idpc", {16'h0, fa.if_id_pc}, 32'h0);
    chk("rst_words", {16'h0, lw[0]}, 32'h0);
    chk("rst_ovf", {31'h0, ov[0]}, 32'h0);
    chk("rst_mode", {30'h0, ld[0], rn[0]}, 32'h0);
    rst = 1'b0;

    enter_load(0);
    chk("load_mode", {31'h0, ld[0]}, 32'h1);
    send_byte(0, 8'h13); send_byte(0, 8'h00);
    send_byte(0, 8'h00); send_byte(0, 8'h00);
    send_byte(0, 8'h93); send_byte(0, 8'h00);
    send_byte(0, 8'h10); send_byte(0, 8'h00);
    chk("load_words2", {16'h0, lw[0]}, 32'h2);
    send_word(0, 32'h0020_0113);
    send_word(0, 32'h0030_0193);
    send_word(0, 32'hAABB_CCDD);
    chk("load_words5", {16'h0, lw[0]}, 32'h5);
    leave_load(0);
    chk("load_exit", {31'h0, ld[0]}, 32'h0);

    pulse_start(0);
    chk("start_run", {31'h0, rn[0]}, 32'h1);
    chk("start_pc", {16'h0, fa.pc}, 32'h0);
    chk("start_valid", {31'h0, fa.if_id_valid}, 32'h0);
    push(32'h0000_0013, 16'h0);
    push(32'h0010_0093, 16'h4);
    push(32'h0020_0113, 16'h8);
    step(); check_fetch(0, "f0");
    chk("f0_nextpc", {16'h0, fa.pc}, 32'h4);
    step(); check_fetch(0, "f1");
    chk("f1_nextpc", {16'h0, fa.pc}, 32'h8);

    fa.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", fa.if_id_instr, 32'h0010_0093);
      chk("stall_idpc", {16'h0, fa.if_id_pc}, 32'h4);
      chk("stall_valid", {31'h0, fa.if_id_valid}, 32'h1);
      chk("stall_pc", {16'h0, fa.pc}, 32'h8);
    end
    fa.stall = 1'b0;
    step(); check_fetch(0, "f2");
    chk("f2_nextpc", {16'h0, fa.pc}, 32'hC);

    fa.redirect_valid = 1'b1;
    fa.redirect_pc    = 16'h0013;
    fa.stall          = 1'b1;
    step();
    fa.redirect_valid = 1'b0;
    fa.stall          = 1'b0;
    chk("redir_pc", {16'h0, fa.pc}, 32'h10);
    chk("redir_bubble", {31'h0, fa.if_id_valid}, 32'h0);
    push(32'hAABB_CCDD, 16'h10);
    step(); check_fetch(0, "redir_tgt");
    chk("redir_nextpc", {16'h0, fa.pc}, 32'h14);

    hl[0] = 1'b1;
    step();
    hl[0] = 1'b0;
    chk("halt_run", {31'h0, rn[0]}, 32'h0);
    chk("halt_valid", {31'h0, fa.if_id_valid}, 32'h0);
    chk("halt_pc", {16'h0, fa.pc}, 32'h14);

    enter_load(0);
    send_word(0, 32'hCAFE_F00D);
    send_byte(0, 8'h55);
    send_byte(0, 8'h66);
    leave_load(0);
    chk("partial_words", {16'h0, lw[0]}, 32'h1);
    pulse_start(0);
    push(32'hCAFE_F00D, 16'h0);
    push(32'h0010_0093, 16'h4);
    step(); check_fetch(0, "part_m0");
    step(); check_fetch(0, "part_m1");

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_run", {31'h0, rn[0]}, 32'h0);
    chk("midrst_pc", {16'h0, fa.pc}, 32'h0);
    chk("midrst_valid", {31'h0, fa.if_id_valid}, 32'h0);

    pulse_start(0);
    push(32'hCAFE_F00D, 16'h0);
    push(32'h0010_0093, 16'h4);
    step(); check_fetch(0, "restart_m0");
    step(); check_fetch(0, "restart_m1");
    hl[0] = 1'b1;
    step();
    hl[0] = 1'b0;

    enter_load(0);
    chk("reload_words", {16'h0, lw[0]}, 32'h0);
    leave_load(0);

    enter_load(1);
    send_word(1, 32'h1111_1111);
    send_word(1, 32'h2222_2222);
    send_word(1, 32'h3333_3333);
    send_word(1, 32'h4444_4444);
    chk("ovf_before", {31'h0, ov[1]}, 32'h1);
    send_word(1, 32'h5555_5555);
    chk("ovf_after", {31'h0, ov[1]}, 32'h1);
    chk("ovf_words", {16'h0, lw[1]}, 32'h5);
    leave_load(1);
    pulse_start(1);
    push(32'h5555_5555, 16'h0);
    push(32'h2222_2222, 16'h4);
    step(); check_fetch(1, "wrap_m0");
    step(); check_fetch(1, "wrap_m1");
    fb.redirect_valid = 1'b1;
    fb.redirect_pc    = 16'h0010;
    step();
    fb.redirect_valid = 1'b0;
    push(32'h5555_5555, 16'h10);
    step(); check_fetch(1, "alias_0x10");

    chk("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch front end for the pipelined core. It owns the program counter, an on-chip instruction memory, a byte-serial program loader fed from the board's 8-bit instruction input, and the IF/ID pipeline register. It adds stall, branch redirect with bubble insertion, a valid bit, and load/run mode control. Its outputs feed the decode stage directly.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of PC and byte addresses
- DATA_WIDTH, 32, instruction word width; fixed at 32 for a 4-byte loader
- IMEM_DEPTH, 256, instruction memory depth in words; power of two, at most 2^(ADDR_WIDTH-2)
- RESET_PC, 0, PC loaded on reset and on start; word-aligned

Ports:
- clk  in  1  single clock; every register updates on its rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  level; requests or holds LOAD mode
- load_byte_valid  in  1  load_byte is valid this cycle
- load_byte  in  8  program byte, little-endian within each word
- start  in  1  pulse; begins execution from IDLE
- halt  in  1  pulse; returns RUN to IDLE
- stall  in  1  hold PC and IF/ID this cycle
- redirect_valid  in  1  branch or jump taken
- redirect_pc  in  ADDR_WIDTH  redirect target
- pc  out  ADDR_WIDTH  current fetch address
- if_id_instr  out  DATA_WIDTH  registered instruction
- if_id_pc  out  ADDR_WIDTH  PC of if_id_instr
- if_id_valid  out  1  if_id_instr is a real instruction
- loading  out  1  state is LOAD
- running  out  1  state is RUN
- load_words  out  ADDR_WIDTH  words written since LOAD was entered
- load_ovf  out  1  sticky; loader wrapped past IMEM_DEPTH

## Operation
- States: IDLE, LOAD, RUN. Reset state is IDLE.
- Reset values: pc = RESET_PC; if_id_instr, if_id_pc, if_id_valid, load_words, load_ovf = 0; byte counter = 0. Memory contents are not reset.
- IDLE:
  - load_en = 1 goes to LOAD and clears the word index, byte counter, load_words and load_ovf.
  - Otherwise, start = 1 goes to RUN with pc = RESET_PC.
  - load_en takes priority over start.
- LOAD:
  - Each load_byte_valid cycle latches a byte into lane byte_cnt. Byte 0 is bits 7:0.
  - byte_cnt increments modulo 4.
  - On the fourth byte, the assembled word is written to mem[word_idx], word_idx increments, and load_words increments.
  - When word_idx wraps from IMEM_DEPTH-1 to 0, load_ovf is set. Later words overwrite from index 0.
  - When load_en deasserts, the state returns to IDLE. A partial word is discarded and the byte counter clears.
  - start, stall and redirect inputs are ignored in LOAD.
- RUN, per cycle, in priority order:
  1. halt: go to IDLE and clear if_id_valid. pc holds.
  2. redirect_valid: set pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00} and clear if_id_valid (bubble). Redirect overrides stall.
  3. stall: pc, if_id_instr, if_id_pc and if_id_valid hold.
  4. Otherwise: if_id_instr = mem[pc word index], if_id_pc = pc, if_id_valid = 1, pc = pc + 4.
- Word index is pc[log2(IMEM_DEPTH)+1:2]. Upper PC bits alias, and the memory wraps silently.
- PC arithmetic is modulo 2^ADDR_WIDTH. pc + 4 from the top address wraps to 0.
- The memory has a combinational read port (RUN only) and a synchronous write port (LOAD only).

## Timing
- Fetch latency is one cycle: the instruction at pc appears on if_id_* after the next edge.
- Start sequence:
  - The start edge sets pc = RESET_PC with if_id_valid = 0.
  - The next edge presents mem[RESET_PC] with valid = 1.
- Redirect sequence:
  - The redirect edge produces one bubble.
  - The target instruction appears valid one edge later.
- A stall held for N cycles freezes the outputs for N cycles. There is no loss or duplication.
- A loader write is visible to a RUN fetch on any cycle after the writing edge.
- Synchronous reset in any state forces the reset values on that edge. Memory is untouched.

## Test plan
- Load 8 bytes 13 00 00 00 93 00 10 00 -> mem[0] = 0x00000013, mem[1] = 0x00100093, load_words = 2. Then start -> if_id_instr is 0x00000013 (pc 0), then 0x00100093 (pc 4); valid = 1 from the second cycle after start.
- RUN with stall high for 3 cycles on a valid instruction -> if_id_* and pc unchanged for 3 cycles; the sequence resumes without a skip.
- redirect_valid with redirect_pc = 0x0013 and stall = 1 -> pc = 0x0010, one cycle with if_id_valid = 0, then if_id_pc = 0x0010.
- LOAD with 6 bytes, then load_en dropped -> load_words = 1 and mem[1] unchanged. Re-entering LOAD clears load_words.
- IMEM_DEPTH = 4, load 5 words -> load_ovf = 1 and mem[0] holds the fifth word. Running from pc = 0x10 fetches mem[0].
- rst asserted mid-RUN -> next cycle: IDLE, pc = RESET_PC, if_id_valid = 0. Memory contents are preserved: a restart fetches the original program.
